pc_redirect_ctrl: RTL and testbench

Fetch-stage PC sequencing controller. Each cycle it decides whether the PC register loads and which next-PC value it loads. Candidates are the fetch-stage prediction, the decode-stage jump, the execute-stage mispredict correction, a trap vector, or PC+4. It also owns the post-reset boot sequence, buffers redirects that arrive while fetch is stalled, and drives the decode/execute flushes. It sits between the hazard unit and the PC register.

---
 rtl/pc_ctrl_pkg.sv | 39 +++
 rtl/redirect_prio_sel.sv | 61 ++++++
 rtl/pc_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage PC redirect controller: FSM states,
// redirect sources (numeric value doubles as priority) and the pending entry.
package pc_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RD_SEQ  = 3'd0,
        RD_PRED = 3'd1,
        RD_JUMP = 3'd2,
        RD_MISP = 3'd3,
        RD_TRAP = 3'd4
    } src_t;

    typedef struct packed {
        logic            valid;
        src_t            src;
        logic [XLEN-1:0] target;
    } pend_t;

    // Flushes caused by accepting a redirect of the given source: {flush_d, flush_e}.
    function automatic logic [1:0] src_flush(input src_t src);
        logic [1:0] fl;
        fl = 2'b00;
        case (src)
            RD_TRAP, RD_MISP: fl = 2'b11;
            RD_JUMP:          fl = 2'b10;
            default:          fl = 2'b00;
        endcase
        return fl;
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational redirect picker.
// Inputs : pc, the four redirect requests with targets, the pending entry.
// Outputs: winning source and target, whether the winner is a fresh request,
//          and the decode/execute flushes caused by accepting it.
module redirect_prio_sel
    import pc_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            mispred,
    input  logic [XLEN-1:0] correct_pc,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  pend_t           pending,
    output src_t            win_src,
    output logic [XLEN-1:0] win_target,
    output logic            win_is_new,
    output logic            flush_d,
    output logic            flush_e
);

    src_t            new_src;
    logic [XLEN-1:0] new_target;

    // Highest-priority fresh request; SEQ (pc+4, wrapping) when nothing is asserted.
    always_comb begin
        new_src    = RD_SEQ;
        new_target = pc + XLEN'(4);
        if (trap) begin
            new_src    = RD_TRAP;
            new_target = trap_vector;
        end else if (mispred) begin
            new_src    = RD_MISP;
            new_target = correct_pc;
        end else if (jump) begin
            new_src    = RD_JUMP;
            new_target = jump_target;
        end else if (pred_taken) begin
            new_src    = RD_PRED;
            new_target = pred_target;
        end
    end

    // A fresh request of equal priority replaces the pending one; only a
    // strictly higher pending entry survives. Pending entries never re-flush.
    always_comb begin
        win_src    = new_src;
        win_target = new_target;
        win_is_new = 1'b1;
        if (pending.valid && (pending.src > new_src)) begin
            win_src    = pending.src;
            win_target = pending.target;
            win_is_new = 1'b0;
        end
        {flush_d, flush_e} = win_is_new ? src_flush(win_src) : 2'b00;
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencing controller: boot sequence, redirect priority,
// stall buffering of redirects and decode/execute flush generation.
// Ports: iClk/iRstN clock and async active-low reset; iPC current PC;
//        iStallF fetch stall; redirect requests/targets (pred, jump,
//        mispredict, trap); oPCEn/oNextPC PC register load; oFlushD/oFlushE
//        pipeline squashes; oBooting high during the boot hold.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iPC,
    input  logic        iStallF,
    input  logic        iPredTakenF,
    input  logic [31:0] iPredTargetF,
    input  logic        iJumpD,
    input  logic [31:0] iJumpTargetD,
    input  logic        iMispredE,
    input  logic [31:0] iCorrectPCE,
    input  logic        iTrap,
    input  logic [31:0] iTrapVector,
    output logic        oPCEn,
    output logic [31:0] oNextPC,
    output logic        oFlushD,
    output logic        oFlushE,
    output logic        oBooting
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    pend_t            pend, pend_nxt;

    src_t             sel_src;
    logic [XLEN-1:0]  sel_target;
    logic             sel_is_new;
    logic             sel_flush_d;
    logic             sel_flush_e;

    redirect_prio_sel u_sel (
        .pc          (iPC),
        .pred_taken  (iPredTakenF),
        .pred_target (iPredTargetF),
        .jump        (iJumpD),
        .jump_target (iJumpTargetD),
        .mispred     (iMispredE),
        .correct_pc  (iCorrectPCE),
        .trap        (iTrap),
        .trap_vector (iTrapVector),
        .pending     (pend),
        .win_src     (sel_src),
        .win_target  (sel_target),
        .win_is_new  (sel_is_new),
        .flush_d     (sel_flush_d),
        .flush_e     (sel_flush_e)
    );

    // State, boot counter and pending entry.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= ST_BOOT;
            cnt   <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next-state and PC-load/flush decision.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        oPCEn     = 1'b0;
        oNextPC   = RESET_VECTOR;
        oFlushD   = 1'b1;
        oFlushE   = 1'b1;
        oBooting  = 1'b1;

        case (state)
            ST_BOOT: begin
                // Gate with reset so a one-cycle boot cannot load while held in reset.
                if (cnt == CNT_LAST) begin
                    oPCEn     = iRstN;
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_RUN, ST_HOLD: begin
                oBooting = 1'b0;
                oNextPC  = sel_target;
                oFlushD  = sel_flush_d;
                oFlushE  = sel_flush_e;
                if (iStallF) begin
                    // Pending is empty in RUN, so the winner here is always a fresh request.
                    if (sel_src != RD_SEQ) begin
                        pend_nxt.valid  = 1'b1;
                        pend_nxt.src    = sel_src;
                        pend_nxt.target = sel_target;
                        state_nxt       = ST_HOLD;
                    end
                end else begin
                    oPCEn     = 1'b1;
                    pend_nxt  = '0;
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
                cnt_nxt   = '0;
                pend_nxt  = '0;
            end
        endcase
    end

    logic unused_ok;
    assign unused_ok = sel_is_new;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// random stimulus, all checked against a behavioural model of the controller.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int          BC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall, pred, jump, misp, trap;
    logic [31:0] pred_t, jump_t, misp_t, trap_t;
    logic        pcen, flush_d, flush_e, booting;
    logic [31:0] next_pc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_boot;
    int          m_cnt;
    bit          m_pv;
    int          m_ps;
    logic [31:0] m_pt;

    // Expected values for the current cycle
    bit          e_pcen, e_fd, e_fe, e_boot;
    logic [31:0] e_next;
    int          e_src;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.RESET_VECTOR(RV), .BOOT_CYCLES(BC)) dut (
        .iClk         (clk),
        .iRstN        (rst_n),
        .iPC          (pc),
        .iStallF      (stall),
        .iPredTakenF  (pred),
        .iPredTargetF (pred_t),
        .iJumpD       (jump),
        .iJumpTargetD (jump_t),
        .iMispredE    (misp),
        .iCorrectPCE  (misp_t),
        .iTrap        (trap),
        .iTrapVector  (trap_t),
        .oPCEn        (pcen),
        .oNextPC      (next_pc),
        .oFlushD      (flush_d),
        .oFlushE      (flush_e),
        .oBooting     (booting)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_cnt  = 0;
        m_pv   = 1'b0;
        m_ps   = 0;
        m_pt   = '0;
    endtask

    // Expected outputs from the priority rules applied to current inputs and model state.
    task automatic model_eval();
        int          nsrc;
        logic [31:0] ntgt;
        e_src = 0;
        if (!rst_n || m_boot) begin
            e_pcen = rst_n && (m_cnt == BC - 1);
            e_next = RV;
            e_fd   = 1'b1;
            e_fe   = 1'b1;
            e_boot = 1'b1;
            return;
        end
        nsrc = 0;
        ntgt = pc + 32'd4;
        if (pred) begin nsrc = 1; ntgt = pred_t; end
        if (jump) begin nsrc = 2; ntgt = jump_t; end
        if (misp) begin nsrc = 3; ntgt = misp_t; end
        if (trap) begin nsrc = 4; ntgt = trap_t; end
        e_boot = 1'b0;
        e_pcen = !stall;
        if (m_pv && m_ps > nsrc) begin
            e_src  = m_ps;
            e_next = m_pt;
            e_fd   = 1'b0;
            e_fe   = 1'b0;
        end else begin
            e_src  = nsrc;
            e_next = ntgt;
            e_fd   = (nsrc >= 2);
            e_fe   = (nsrc >= 3);
        end
    endtask

    task automatic eval();
        #1;
        model_eval();
        check("pcen",    32'(pcen),    32'(e_pcen));
        check("next_pc", next_pc,      e_next);
        check("flush_d", 32'(flush_d), 32'(e_fd));
        check("flush_e", 32'(flush_e), 32'(e_fe));
        check("booting", 32'(booting), 32'(e_boot));
    endtask

    // Clock edge: advance the model (including the PC register) with the expectations just computed.
    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_boot) begin
            if (m_cnt == BC - 1) begin
                m_boot = 1'b0;
                pc     = RV;
            end else begin
                m_cnt++;
            end
        end else if (stall) begin
            if (e_src != 0) begin
                m_pv = 1'b1;
                m_ps = e_src;
                m_pt = e_next;
            end
        end else begin
            m_pv = 1'b0;
            pc   = e_next;
        end
        @(negedge clk);
    endtask

    task automatic clear_req();
        stall = 0; pred = 0; jump = 0; misp = 0; trap = 0;
    endtask

    initial begin
        rst_n = 0;
        pc = 32'h0;
        pred_t = 32'h400; jump_t = 32'h300; misp_t = 32'h500; trap_t = 32'h80;
        clear_req();
        model_reset();
        @(negedge clk);

        // Reset held: requests must be ignored
        trap = 1; misp = 1;
        eval();
        check("rst_pcen", 32'(pcen), 32'd0);
        check("rst_next", next_pc, RV);
        adv();
        clear_req();
        eval();
        adv();

        // Boot sequence
        rst_n = 1;
        eval();
        check("boot0_pcen", 32'(pcen), 32'd0);
        adv();
        eval();
        check("boot1_pcen", 32'(pcen), 32'd1);
        check("boot1_next", next_pc, 32'h100);
        adv();
        eval();
        check("post_boot_next", next_pc, 32'h104);
        check("post_boot_booting", 32'(booting), 32'd0);
        adv();

        // Coincident pred/jump/misp: mispredict wins with both flushes
        pc = 32'h200; pred = 1; jump = 1; misp = 1;
        eval();
        check("prio_next", next_pc, 32'h500);
        check("prio_fe", 32'(flush_e), 32'd1);
        adv();

        // Stall: jump latched, later pred dropped
        clear_req(); stall = 1; jump = 1;
        eval();
        check("hold_c1_fd", 32'(flush_d), 32'd1);
        adv();
        jump = 0; pred = 1;
        eval();
        check("hold_c2_fd", 32'(flush_d), 32'd0);
        adv();
        pred = 0;
        eval();
        adv();
        stall = 0;
        eval();
        check("hold_apply_next", next_pc, 32'h300);
        check("hold_apply_pcen", 32'(pcen), 32'd1);
        check("hold_apply_fd", 32'(flush_d), 32'd0);
        adv();

        // Trap overwrites a pending jump
        stall = 1; jump = 1;
        eval(); adv();
        jump = 0; trap = 1;
        eval(); adv();
        trap = 0;
        eval(); adv();
        stall = 0;
        eval();
        check("trap_over_next", next_pc, 32'h80);
        adv();

        // PC+4 wrap
        pc = 32'hFFFF_FFFC;
        eval();
        check("wrap_next", next_pc, 32'h0);
        adv();

        // Reset in HOLD discards the pending entry
        stall = 1; jump = 1;
        eval(); adv();
        jump = 0;
        rst_n = 0;
        eval();
        check("rst_hold_boot", 32'(booting), 32'd1);
        adv();
        rst_n = 1; stall = 0;
        eval(); adv();
        eval();
        check("rst_hold_reload", next_pc, RV);
        adv();
        eval();
        check("rst_hold_after", next_pc, 32'h104);
        adv();

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            stall  = ($urandom_range(0, 99) < 45);
            pred   = ($urandom_range(0, 99) < 30);
            jump   = ($urandom_range(0, 99) < 20);
            misp   = ($urandom_range(0, 99) < 12);
            trap   = ($urandom_range(0, 99) < 6);
            pred_t = $urandom() & 32'hFFFF_FFFC;
            jump_t = $urandom() & 32'hFFFF_FFFC;
            misp_t = $urandom() & 32'hFFFF_FFFC;
            trap_t = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
            rst_n  = ($urandom_range(0, 79) != 0);
            eval();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
